// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the single-SRAM fetch/data arbiter.
// Port ids double as bit positions in the arbiter's request vector.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } port_e;

  localparam logic [31:0] DONE_ADDR_DEF = 32'h0000_FFFF;
  localparam logic [31:0] DONE_DATA_DEF = 32'h0000_DEAD;

endpackage

// File: rtl/rv_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port
// that was not granted last. The last_grant register lives in the parent.
module rv_rr_arb2
  import rv_mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_e      last_grant_i,
  output port_e      grant_o
);

  always_comb begin
    grant_o = FETCH;
    case (req_i)
      2'b01:   grant_o = FETCH;
      2'b10:   grant_o = DATA;
      2'b11:   grant_o = (last_grant_i == FETCH) ? DATA : FETCH;
      default: grant_o = last_grant_i;
    endcase
  end

endmodule

// File: rtl/rv_mem_arb.sv
// Shares one single-port synchronous SRAM between the core's fetch and data
// ports; also decodes the completion write into a sticky halt.
module rv_mem_arb
  import rv_mem_pkg::*;
#(
  parameter int                 DPWIDTH     = 32,
  parameter int                 LOGMEM_SIZE = 10,
  parameter logic [DPWIDTH-1:0] DONE_ADDR   = DPWIDTH'(DONE_ADDR_DEF),
  parameter logic [DPWIDTH-1:0] DONE_DATA   = DPWIDTH'(DONE_DATA_DEF)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [DPWIDTH-1:0]     if_addr,
  output logic                   if_ack,
  output logic [DPWIDTH-1:0]     if_rdata,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [DPWIDTH-1:0]     d_addr,
  input  logic [DPWIDTH-1:0]     d_wdata,
  output logic                   d_ack,
  output logic [DPWIDTH-1:0]     d_rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [LOGMEM_SIZE-1:0] mem_addr,
  output logic [DPWIDTH-1:0]     mem_wdata,
  input  logic [DPWIDTH-1:0]     mem_rdata,
  output logic                   err,
  output logic                   halt
);

  state_e                 state_q;
  port_e                  lastGrant_q;
  port_e                  winner_q;
  port_e                  grant;
  logic                   memEn_q;
  logic                   memWe_q;
  logic [LOGMEM_SIZE-1:0] memAddr_q;
  logic [DPWIDTH-1:0]     memWdata_q;
  logic                   ifAck_q;
  logic                   dAck_q;
  logic                   err_q;
  logic                   halt_q;
  logic                   legal_q;
  logic                   done_q;
  logic                   rdOk_q;

  logic [1:0]             reqVec;
  logic [DPWIDTH-1:0]     selAddr;
  logic                   selWe;
  logic                   isDone;
  logic                   isLegal;
  logic [LOGMEM_SIZE-1:0] memAddr_d;
  logic [DPWIDTH-1:0]     memWdata_d;

  assign reqVec = {d_req, if_req};

  rv_rr_arb2 uArb (
    .req_i        (reqVec),
    .last_grant_i (lastGrant_q),
    .grant_o      (grant)
  );

  // The completion write is recognised before legality, so its misaligned
  // address never raises err.
  assign selAddr    = (grant == DATA) ? d_addr : if_addr;
  assign selWe      = (grant == DATA) && d_we;
  assign isDone     = selWe && (d_addr == DONE_ADDR) && (d_wdata == DONE_DATA);
  assign isLegal    = (selAddr[1:0] == 2'b00) &&
                      (selAddr[DPWIDTH-1:LOGMEM_SIZE+2] == '0);
  assign memAddr_d  = selAddr[LOGMEM_SIZE+1:2];
  assign memWdata_d = (grant == DATA) ? d_wdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      lastGrant_q <= FETCH;
      winner_q    <= FETCH;
      memEn_q     <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      ifAck_q     <= 1'b0;
      dAck_q      <= 1'b0;
      err_q       <= 1'b0;
      halt_q      <= 1'b0;
      legal_q     <= 1'b0;
      done_q      <= 1'b0;
      rdOk_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((if_req || d_req) && !halt_q) begin
            winner_q    <= grant;
            lastGrant_q <= grant;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            legal_q     <= isLegal;
            done_q      <= isDone;
            rdOk_q      <= isLegal && !selWe;
            memEn_q     <= isLegal && !isDone;
            memWe_q     <= isLegal && !isDone && selWe;
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          memEn_q <= 1'b0;
          memWe_q <= 1'b0;
          ifAck_q <= (winner_q == FETCH);
          dAck_q  <= (winner_q == DATA);
          err_q   <= !legal_q && !done_q;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          ifAck_q <= 1'b0;
          dAck_q  <= 1'b0;
          err_q   <= 1'b0;
          if (done_q) halt_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // SRAM read data arrives in the RESP cycle, so it is steered straight out.
  assign if_rdata  = (ifAck_q && rdOk_q) ? mem_rdata : '0;
  assign d_rdata   = (dAck_q && rdOk_q) ? mem_rdata : '0;
  assign if_ack    = ifAck_q;
  assign d_ack     = dAck_q;
  assign mem_en    = memEn_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign err       = err_q;
  assign halt      = halt_q;

endmodule
